// File: rtl/fft_sched_pkg.sv
// Shared types and default sizes for the FFT frame scheduler.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPUTE = 2'd2,
        READOUT = 2'd3
    } phase_t;

    localparam int N_SAMPLES_DEF = 512;
    localparam int ADDR_W_DEF    = 9;
    localparam int DATA_W_DEF    = 16;

endpackage

// File: rtl/fft_frame_sched_sram_port_mux.sv
// Phase-indexed mux of the capture, engine and readout requesters onto the single SRAM port.
module sram_port_mux
    import fft_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  phase_t            phase,
    input  logic              cap_write_ena,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_wdata,
    input  logic              eng_read_ena,
    input  logic              eng_write_ena,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    input  logic              rd_read_ena,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              sram_read_ena,
    output logic              sram_write_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata
);

    always_comb begin
        sram_read_ena  = 1'b0;
        sram_write_ena = 1'b0;
        sram_addr      = '0;
        sram_wdata     = '0;
        case (phase)
            CAPTURE: begin
                sram_write_ena = cap_write_ena;
                sram_addr      = cap_addr;
                sram_wdata     = cap_wdata;
            end
            COMPUTE: begin
                // A simultaneous engine read and write resolves to the write.
                sram_write_ena = eng_write_ena;
                sram_read_ena  = eng_read_ena && !eng_write_ena;
                sram_addr      = eng_addr;
                sram_wdata     = eng_wdata;
            end
            READOUT: begin
                sram_read_ena = rd_read_ena;
                sram_addr     = rd_addr;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 512-point FFT: capture, engine compute and result readout,
// sharing one single-port sample SRAM.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int N_SAMPLES   = N_SAMPLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FFT_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_go,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    output logic              fft_start,
    input  logic              fft_done,
    input  logic              eng_read_ena,
    input  logic              eng_write_ena,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sram_read_ena,
    output logic              sram_write_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        phase,
    output logic              overrun,
    output logic              fft_err
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(FFT_TIMEOUT + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SAMPLES - 1);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(N_SAMPLES);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(FFT_TIMEOUT);

    phase_t              phase_q, phase_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic cap_we;
    logic rd_issue;
    logic rd_handshake;
    logic timeout_hit;

    assign cap_we       = (phase_q == CAPTURE) && smp_valid;
    assign rd_handshake = out_valid_q && out_ready;
    // One read in flight at most; a new one may go out in the same cycle the held word is taken.
    assign rd_issue     = (phase_q == READOUT) && !rd_pend_q
                          && (!out_valid_q || out_ready) && (rd_ptr_q < FULL_CNT);
    assign timeout_hit  = (phase_q == COMPUTE) && !fft_done && (to_cnt_q == TO_LIMIT);

    assign smp_ready = (phase_q == CAPTURE);
    assign fft_start = (phase_q == COMPUTE) && (to_cnt_q == '0);
    assign fft_err   = timeout_hit;
    assign overrun   = smp_valid && (phase_q != CAPTURE);
    assign phase     = phase_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign eng_rdata = sram_rdata;

    always_comb begin
        phase_d     = phase_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        to_cnt_d    = to_cnt_q;
        rd_pend_d   = rd_issue;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        // rd_ptr has already advanced past the returning word, so FULL_CNT marks the last one.
        if (rd_pend_q) begin
            out_data_d  = sram_rdata;
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q == FULL_CNT);
        end else if (rd_handshake) begin
            out_valid_d = 1'b0;
        end

        case (phase_q)
            IDLE: begin
                if (frame_go) begin
                    phase_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end
            CAPTURE: begin
                if (cap_we) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_IDX) begin
                        phase_d  = COMPUTE;
                        to_cnt_d = '0;
                    end
                end
            end
            COMPUTE: begin
                if (fft_done) begin
                    phase_d  = READOUT;
                    rd_ptr_d = '0;
                end else if (timeout_hit) begin
                    phase_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            READOUT: begin
                if (rd_issue) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (rd_handshake && out_last_q) begin
                    phase_d  = frame_go ? CAPTURE : IDLE;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                phase_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            phase_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            to_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            to_cnt_q    <= to_cnt_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .phase          (phase_q),
        .cap_write_ena  (cap_we),
        .cap_addr       (wr_ptr_q[ADDR_W-1:0]),
        .cap_wdata      (smp_data),
        .eng_read_ena   (eng_read_ena),
        .eng_write_ena  (eng_write_ena),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata),
        .rd_read_ena    (rd_issue),
        .rd_addr        (rd_ptr_q[ADDR_W-1:0]),
        .sram_read_ena  (sram_read_ena),
        .sram_write_ena (sram_write_ena),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata)
    );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized bench for fft_frame_sched: behavioural SRAM, reference memory image and
// frame-level expectations for capture, compute, readout, overrun, timeout and reset.
module tb_fft_frame_sched;

    localparam int N       = 512;
    localparam int AW      = 9;
    localparam int DW      = 16;
    localparam int TIMEOUT = 120;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          frame_go;
    logic          smp_valid;
    logic [DW-1:0] smp_data;
    logic          smp_ready;
    logic          fft_start;
    logic          fft_done;
    logic          eng_read_ena;
    logic          eng_write_ena;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic [DW-1:0] eng_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          sram_read_ena;
    logic          sram_write_ena;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [1:0]    phase;
    logic          overrun;
    logic          fft_err;

    logic [DW-1:0] sram_mem [N];
    logic [DW-1:0] ref_mem  [N];

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;
    int ovr_cnt   = 0;
    int err_cnt   = 0;

    fft_frame_sched #(
        .N_SAMPLES   (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FFT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .frame_go       (frame_go),
        .smp_valid      (smp_valid),
        .smp_data       (smp_data),
        .smp_ready      (smp_ready),
        .fft_start      (fft_start),
        .fft_done       (fft_done),
        .eng_read_ena   (eng_read_ena),
        .eng_write_ena  (eng_write_ena),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata),
        .eng_rdata      (eng_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .sram_read_ena  (sram_read_ena),
        .sram_write_ena (sram_write_ena),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .phase          (phase),
        .overrun        (overrun),
        .fft_err        (fft_err)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (sram_write_ena) sram_mem[sram_addr] <= sram_wdata;
        if (sram_read_ena)  sram_rdata <= sram_mem[sram_addr];
    end

    always @(posedge clk) begin
        if (fft_start) start_cnt <= start_cnt + 1;
        if (overrun)   ovr_cnt   <= ovr_cnt + 1;
        if (fft_err)   err_cnt   <= err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and put every input in its quiet state.
    task automatic applyStimulus();
        @(negedge clk);
        n_rst         = 1'b0;
        frame_go      = 1'b0;
        smp_valid     = 1'b0;
        smp_data      = 16'($urandom);
        fft_done      = 1'b0;
        eng_read_ena  = 1'b0;
        eng_write_ena = 1'b0;
        eng_addr      = '0;
        eng_wdata     = '0;
        out_ready     = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_phase"}, 32'(phase), 0);
        checkOutput({tag, "_ready"}, 32'(smp_ready), 0);
        checkOutput({tag, "_start"}, 32'(fft_start), 0);
        checkOutput({tag, "_err"}, 32'(fft_err), 0);
        checkOutput({tag, "_ovr"}, 32'(overrun), 0);
        checkOutput({tag, "_oval"}, 32'(out_valid), 0);
        checkOutput({tag, "_olast"}, 32'(out_last), 0);
        checkOutput({tag, "_odata"}, 32'(out_data), 0);
        checkOutput({tag, "_re"}, 32'(sram_read_ena), 0);
        checkOutput({tag, "_we"}, 32'(sram_write_ena), 0);
        checkOutput({tag, "_addr"}, 32'(sram_addr), 0);
        checkOutput({tag, "_wdata"}, 32'(sram_wdata), 0);
    endtask

    task automatic runCapture(input bit from_idle, input int stop_at, input bit inject_done);
        int idx = 0;
        int cyc = 0;
        if (from_idle) begin
            applyStimulus();
            frame_go = 1'b1;
            #1;
            checkOutput("go_phase", 32'(phase), 0);
            checkOutput("go_we", 32'(sram_write_ena), 0);
        end
        while (idx < stop_at && cyc < 4 * N) begin
            applyStimulus();
            cyc++;
            smp_valid = ($urandom_range(0, 3) != 0);
            if (inject_done && $urandom_range(0, 7) == 0) fft_done = 1'b1;
            #1;
            checkOutput("cap_phase", 32'(phase), 1);
            checkOutput("cap_ready", 32'(smp_ready), 1);
            checkOutput("cap_ovr", 32'(overrun), 0);
            checkOutput("cap_start", 32'(fft_start), 0);
            checkOutput("cap_we", 32'(sram_write_ena), 32'(smp_valid));
            if (smp_valid) begin
                checkOutput("cap_addr", 32'(sram_addr), 32'(idx));
                checkOutput("cap_wdata", 32'(sram_wdata), 32'(smp_data));
                ref_mem[idx] = smp_data;
                idx++;
            end
        end
        checkOutput("cap_count", 32'(idx), 32'(stop_at));
    endtask

    task automatic runCompute(input int done_delay, input bit with_conflict,
                              input bit with_overrun, input bit expect_timeout);
        bit            pend_rd  = 1'b0;
        logic [DW-1:0] pend_exp = '0;
        int            last_k   = expect_timeout ? TIMEOUT : done_delay;
        int            r;
        for (int k = 0; k <= last_k; k++) begin
            applyStimulus();
            r = $urandom_range(0, 3);
            if (k == last_k && !expect_timeout) begin
                fft_done      = 1'b1;
                eng_write_ena = 1'b1;
                eng_addr      = 9'($urandom);
                eng_wdata     = 16'($urandom);
            end else if (with_conflict && k == 3) begin
                eng_read_ena  = 1'b1;
                eng_write_ena = 1'b1;
                eng_addr      = 9'd5;
                eng_wdata     = 16'hBEEF;
            end else if (with_overrun && k == 2) begin
                smp_valid = 1'b1;
            end else if (r == 0) begin
                eng_write_ena = 1'b1;
                eng_addr      = 9'($urandom);
                eng_wdata     = 16'($urandom);
            end else if (r == 1) begin
                eng_read_ena = 1'b1;
                eng_addr     = 9'($urandom);
            end
            #1;
            if (pend_rd) checkOutput("eng_rdata", 32'(eng_rdata), 32'(pend_exp));
            pend_rd = 1'b0;
            checkOutput("cmp_phase", 32'(phase), 2);
            checkOutput("cmp_start", 32'(fft_start), 32'(k == 0));
            checkOutput("cmp_err", 32'(fft_err), 32'(expect_timeout && k == TIMEOUT));
            checkOutput("cmp_ovr", 32'(overrun), 32'(smp_valid));
            checkOutput("cmp_we", 32'(sram_write_ena), 32'(eng_write_ena));
            checkOutput("cmp_re", 32'(sram_read_ena), 32'(eng_read_ena && !eng_write_ena));
            if (eng_read_ena || eng_write_ena)
                checkOutput("cmp_addr", 32'(sram_addr), 32'(eng_addr));
            if (eng_write_ena) begin
                checkOutput("cmp_wdata", 32'(sram_wdata), 32'(eng_wdata));
                ref_mem[eng_addr] = eng_wdata;
            end else if (eng_read_ena) begin
                pend_rd  = 1'b1;
                pend_exp = ref_mem[eng_addr];
            end
        end
    endtask

    task automatic runReadout(input int mode, input bit rearm);
        int            words      = 0;
        int            issued     = 0;
        int            cyc        = 0;
        int            stall_left = 0;
        bit            stalled    = 1'b0;
        logic [DW-1:0] held       = '0;
        while (words < N && cyc < 16 * N) begin
            applyStimulus();
            cyc++;
            frame_go = rearm;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if ($urandom_range(0, 15) == 0) begin
                        out_ready  = 1'b0;
                        stall_left = 2;
                    end else begin
                        out_ready = (cyc % 2 == 1);
                    end
                end
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            #1;
            checkOutput("rd_phase", 32'(phase), 3);
            if (stalled) checkOutput("rd_hold", 32'(out_data), 32'(held));
            if (out_valid && !out_ready) checkOutput("rd_stall_re", 32'(sram_read_ena), 0);
            if (sram_read_ena) begin
                checkOutput("rd_addr", 32'(sram_addr), 32'(issued));
                issued++;
            end
            if (out_valid) checkOutput("rd_last", 32'(out_last), 32'(words == N - 1));
            if (out_valid && out_ready) begin
                checkOutput("rd_data", 32'(out_data), 32'(ref_mem[words]));
                words++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
        checkOutput("rd_words", 32'(words), N);
        checkOutput("rd_issued", 32'(issued), N);
        if (mode == 0) checkOutput("rd_cycles", 32'(cyc), 2 * N + 1);
        applyStimulus();
        frame_go = rearm;
        #1;
        checkOutput("rd_next_phase", 32'(phase), rearm ? 1 : 0);
        checkOutput("rd_next_oval", 32'(out_valid), 0);
    endtask

    initial begin
        bit seen;
        n_rst         = 1'b1;
        frame_go      = 1'b0;
        smp_valid     = 1'b0;
        smp_data      = '0;
        fft_done      = 1'b0;
        eng_read_ena  = 1'b0;
        eng_write_ena = 1'b0;
        eng_addr      = '0;
        eng_wdata     = '0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus();
        #1;
        checkAllZero("rst");

        applyStimulus();
        smp_valid = 1'b1;
        #1;
        checkOutput("idle_ovr", 32'(overrun), 1);
        checkOutput("idle_ovr_we", 32'(sram_write_ena), 0);
        applyStimulus();
        #1;
        checkOutput("idle_ovr_phase", 32'(phase), 0);

        $display("[TB] frame 1: full frame, conflict, overrun, re-arm");
        runCapture(1'b1, N, 1'b1);
        runCompute(100, 1'b1, 1'b1, 1'b0);
        runReadout(0, 1'b1);
        checkOutput("start_cnt_f1", 32'(start_cnt), 1);

        $display("[TB] frame 2: toggling backpressure with stalls");
        runCapture(1'b0, N, 1'b0);
        runCompute($urandom_range(10, 100), 1'b0, 1'b0, 1'b0);
        runReadout(1, 1'b0);

        $display("[TB] frame 3: random backpressure");
        runCapture(1'b1, N, 1'b1);
        runCompute($urandom_range(10, 100), 1'b0, 1'b1, 1'b0);
        runReadout(2, 1'b0);

        $display("[TB] timeout frame");
        runCapture(1'b1, N, 1'b0);
        runCompute(0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        eng_read_ena  = 1'b1;
        eng_write_ena = 1'b1;
        #1;
        checkOutput("to_phase", 32'(phase), 0);
        checkOutput("to_re", 32'(sram_read_ena), 0);
        checkOutput("to_we", 32'(sram_write_ena), 0);
        checkOutput("to_err_after", 32'(fft_err), 0);
        checkOutput("to_err_cnt", 32'(err_cnt), 1);

        $display("[TB] reset during capture");
        runCapture(1'b1, 200, 1'b0);
        applyStimulus();
        n_rst = 1'b1;
        #1;
        applyStimulus();
        #1;
        checkAllZero("rst_cap");

        $display("[TB] reset during readout");
        runCapture(1'b1, N, 1'b0);
        runCompute($urandom_range(10, 100), 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus();
            #1;
            seen = out_valid;
        end
        checkOutput("rr_valid", 32'(seen), 1);
        applyStimulus();
        n_rst = 1'b1;
        #1;
        applyStimulus();
        #1;
        checkAllZero("rst_rd");

        $display("[TB] frame after reset");
        runCapture(1'b1, N, 1'b0);
        runCompute($urandom_range(10, 100), 1'b0, 1'b0, 1'b0);
        runReadout(0, 1'b0);

        checkOutput("start_cnt", 32'(start_cnt), 6);
        checkOutput("ovr_cnt", 32'(ovr_cnt), 3);
        checkOutput("err_cnt", 32'(err_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
